// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Memory is word-wide; the low byte-offset bits never reach m_addr.
  localparam int ALIGN_BITS = 2;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner select between fetch and data requesters at an arbitration point.
// Latency: purely combinational.
// Backpressure: none; result only meaningful when at least one request is set.
module arb_pick
  import mem_arb_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
  parameter int MAX_WAIT = 4
)
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic [2:0] wait_cnt,
  output owner_t     winner
);
`else
(
  input  logic   i_req,
  input  logic   d_req,
  output owner_t winner
);
`endif

  // Data has priority; the guard build hands one contest to fetch once it has lost MAX_WAIT times.
  always_comb begin
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (i_req && (!d_req || (wait_cnt == 3'(MAX_WAIT)))) begin
      winner = OWN_I;
    end else begin
      winner = OWN_D;
    end
`else
    if (i_req && !d_req) begin
      winner = OWN_I;
    end else begin
      winner = OWN_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requesters onto one single-port memory.
// Latency: request seen in IDLE -> gnt next cycle -> rvalid the cycle after; one access per 2 cycles peak.
// Backpressure: requesters hold req until gnt; a req dropped before capture is withdrawn silently.
// Optional build macro MEM_ARB_STARVE_GUARD_EN: fetch is forced through after MAX_WAIT losses to data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 32
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  state_t                         state;
  state_t                         state_nxt;
  owner_t                         owner;
  owner_t                         winner;
  logic [ADDR_W-1:ALIGN_BITS]     cmd_addr;
  logic [3:0]                     cmd_we;
  logic [31:0]                    cmd_wdata;
  logic                           any_req;
  logic                           capture;

  // Byte offsets within a word are meaningless to a word-wide memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[ALIGN_BITS-1:0], d_addr[ALIGN_BITS-1:0]};

  assign any_req = i_req | d_req;
  // IDLE and RESP are the only points where requests are sampled.
  assign capture = any_req && ((state == ST_IDLE) || (state == ST_RESP));

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] wait_cnt;

  arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .wait_cnt (wait_cnt),
    .winner   (winner)
  );

  // Count fetch losses to data (saturating); any fetch win clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 3'd0;
    end else if (capture) begin
      if (winner == OWN_I) begin
        wait_cnt <= 3'd0;
      end else if (i_req && (wait_cnt != 3'd7)) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end
`else
  arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .winner (winner)
  );
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a pending request in RESP chains straight into the next ISSUE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = any_req ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = any_req ? ST_ISSUE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning command; later changes on the request inputs are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_I;
      cmd_addr  <= '0;
      cmd_we    <= 4'd0;
      cmd_wdata <= 32'd0;
    end else if (capture) begin
      owner <= winner;
      if (winner == OWN_D) begin
        cmd_addr  <= d_addr[ADDR_W-1:ALIGN_BITS];
        cmd_we    <= d_we;
        cmd_wdata <= d_wdata;
      end else begin
        cmd_addr  <= i_addr[ADDR_W-1:ALIGN_BITS];
        cmd_we    <= 4'd0;
        cmd_wdata <= 32'd0;
      end
    end
  end

  // Outputs: memory command in ISSUE, owner response in RESP, everything else held at 0.
  always_comb begin
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = 32'd0;
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = 32'd0;
    m_en     = 1'b0;
    m_we     = 4'd0;
    m_addr   = '0;
    m_wdata  = 32'd0;
    case (state)
      ST_ISSUE: begin
        m_en    = 1'b1;
        m_we    = cmd_we;
        m_addr  = {cmd_addr, {ALIGN_BITS{1'b0}}};
        m_wdata = cmd_wdata;
        if (owner == OWN_D) begin
          d_gnt = 1'b1;
        end else begin
          i_gnt = 1'b1;
        end
      end
      ST_RESP: begin
        if (owner == OWN_D) begin
          d_rvalid = 1'b1;
          // Stores complete with a pulse but carry no data.
          d_rdata  = (cmd_we == 4'd0) ? m_rdata : 32'd0;
        end else begin
          i_rvalid = 1'b1;
          i_rdata  = m_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a command/response scoreboard.
// Latency: memory model returns data one cycle after m_en.
// Backpressure: requests held until gnt, as a real requester would.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [3:0]  m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  mem_arbiter #(.MAX_WAIT(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  // Memory model: read data one cycle after m_en, noise otherwise.
  always @(posedge clk) m_rdata <= m_en ? mem_val(m_addr) : $urandom();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    cmd_q.push_back('{is_d: 1'b0, addr: {a[31:2], 2'b00}, we: 4'd0, wdata: 32'd0});
    rsp_q.push_back('{is_d: 1'b0, data: mem_val(a)});
  endtask

  task automatic exp_data(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    cmd_q.push_back('{is_d: 1'b1, addr: {a[31:2], 2'b00}, we: we, wdata: wd});
    rsp_q.push_back('{is_d: 1'b1, data: (we == 4'd0) ? mem_val(a) : 32'd0});
  endtask

  // Scoreboard and invariant monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid)) begin
        errors++;
        $display("FAIL exclusive: gnt=%b%b rvalid=%b%b, required at most one owner", i_gnt, d_gnt, i_rvalid, d_rvalid);
      end
      checks++;
      if ((!i_rvalid && i_rdata !== 32'd0) || (!d_rvalid && d_rdata !== 32'd0) ||
          (!m_en && ({m_we, m_addr, m_wdata} !== '0)) || (!m_en && (i_gnt || d_gnt)) ||
          (m_en && !i_gnt && !d_gnt)) begin
        errors++;
        $display("FAIL quiet_outputs: i_rdata=%h d_rdata=%h m_en=%b m_addr=%h gnt=%b%b, required zero outside owner/ISSUE",
                 i_rdata, d_rdata, m_en, m_addr, i_gnt, d_gnt);
      end
      if (m_en) begin
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd: m_addr=%h, required no command", m_addr);
        end else begin
          cmd_t c;
          c = cmd_q.pop_front();
          if ({d_gnt, i_gnt, m_addr, m_we, m_wdata} !== {c.is_d, !c.is_d, c.addr, c.we, c.wdata}) begin
            errors++;
            $display("FAIL cmd: gnt d/i=%b%b addr=%h we=%b wdata=%h, required d=%b addr=%h we=%b wdata=%h",
                     d_gnt, i_gnt, m_addr, m_we, m_wdata, c.is_d, c.addr, c.we, c.wdata);
          end
        end
      end
      if (i_rvalid || d_rvalid) begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rvalid d/i=%b%b, required none", d_rvalid, i_rvalid);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          if ({d_rvalid, (d_rvalid ? d_rdata : i_rdata)} !== {r.is_d, r.data}) begin
            errors++;
            $display("FAIL rsp: d_rvalid=%b data=%h, required d=%b data=%h",
                     d_rvalid, (d_rvalid ? d_rdata : i_rdata), r.is_d, r.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'h10; d_addr = 32'h20; d_we = 4'd0; d_wdata = 32'd0;
    #2;
    checks++;
    if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_addr, m_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: m_en=%b i_gnt=%b d_gnt=%b, required all zero", m_en, i_gnt, d_gnt);
    end
    step();
    step();
    checks++;
    if ({i_gnt, d_gnt, m_en, i_rvalid, d_rvalid} !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold: gnt=%b%b m_en=%b, required zero while in reset", i_gnt, d_gnt, m_en);
    end
    i_req = 1'b0; d_req = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    i_addr = 32'h0000_0104;
    i_req  = 1'b1;
    exp_fetch(32'h0000_0104);
    step();
    checks++;
    if ({i_gnt, m_en, m_addr} !== {1'b1, 1'b1, 32'h104}) begin
      errors++;
      $display("FAIL fetch_issue: i_gnt=%b m_en=%b m_addr=%h, required 1 1 00000104", i_gnt, m_en, m_addr);
    end
    i_req = 1'b0;
    step();
    checks++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'hC0DE_0104}) begin
      errors++;
      $display("FAIL fetch_rsp: i_rvalid=%b i_rdata=%h, required 1 c0de0104", i_rvalid, i_rdata);
    end
    step();
  endtask

  task automatic test_priority();
    i_addr = 32'h300; d_addr = 32'h2000; d_we = 4'd0; d_wdata = 32'h1234_5678;
    exp_data(32'h2000, 4'd0, 32'h1234_5678);
    exp_fetch(32'h300);
    i_req = 1'b1; d_req = 1'b1;
    step();
    checks++;
    if ({d_gnt, i_gnt, m_addr} !== {1'b1, 1'b0, 32'h2000}) begin
      errors++;
      $display("FAIL prio_data_first: d_gnt=%b i_gnt=%b m_addr=%h, required 1 0 00002000", d_gnt, i_gnt, m_addr);
    end
    d_req = 1'b0;
    step();
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, mem_val(32'h2000)}) begin
      errors++;
      $display("FAIL prio_data_rsp: d_rvalid=%b d_rdata=%h, required 1 %h", d_rvalid, d_rdata, mem_val(32'h2000));
    end
    step();
    checks++;
    if ({i_gnt, m_addr} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL prio_fetch_next: i_gnt=%b m_addr=%h, required 1 00000300", i_gnt, m_addr);
    end
    i_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_store();
    d_addr = 32'h2002; d_we = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    exp_data(32'h2002, 4'b0011, 32'hDEAD_BEEF);
    d_req = 1'b1;
    step();
    checks++;
    if ({d_gnt, m_addr, m_we, m_wdata} !== {1'b1, 32'h2000, 4'b0011, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_issue: d_gnt=%b m_addr=%h m_we=%b m_wdata=%h, required 1 00002000 0011 deadbeef",
               d_gnt, m_addr, m_we, m_wdata);
    end
    d_req = 1'b0; d_we = 4'd0;
    step();
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL store_rsp: d_rvalid=%b d_rdata=%h, required 1 00000000", d_rvalid, d_rdata);
    end
    step();
  endtask

  task automatic test_withdraw();
    i_addr = 32'h500;
    i_req  = 1'b1;
    #3;
    i_req  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({i_gnt, m_en, i_rvalid} !== 3'b000) begin
        errors++;
        $display("FAIL withdraw: cycle %0d i_gnt=%b m_en=%b i_rvalid=%b, required 000", k, i_gnt, m_en, i_rvalid);
      end
    end
  endtask

  task automatic test_starve();
    int n_d;
    int n_i;
    int first_i;
    n_d = 0; n_i = 0; first_i = -1;
    i_addr = 32'h400; d_addr = 32'h2040; d_we = 4'd0; d_wdata = 32'd0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) exp_data(32'h2040, 4'd0, 32'd0);
    exp_fetch(32'h400);
    exp_data(32'h2040, 4'd0, 32'd0);
`else
    for (int k = 0; k < 6; k++) exp_data(32'h2040, 4'd0, 32'd0);
`endif
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (d_gnt) n_d++;
      if (i_gnt) begin
        n_i++;
        if (first_i < 0) first_i = k;
        i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    step();
    checks++;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (n_d != 5 || n_i != 1 || first_i != 9) begin
      errors++;
      $display("FAIL starve_guard: d grants=%0d i grants=%0d first i cycle=%0d, required 5 1 9", n_d, n_i, first_i);
    end
`else
    if (n_d != 6 || n_i != 0) begin
      errors++;
      $display("FAIL strict_priority: d grants=%0d i grants=%0d, required 6 0", n_d, n_i);
    end
`endif
  endtask

  task automatic test_reset_mid();
    i_addr = 32'h600;
    i_req  = 1'b1;
    cmd_q.push_back('{is_d: 1'b0, addr: 32'h600, we: 4'd0, wdata: 32'd0});
    step();
    i_req = 1'b0;
    step();
    checks++;
    if (i_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_resp_state: i_rvalid=%b, required 1", i_rvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_addr, m_wdata} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: i_rvalid=%b i_rdata=%h m_en=%b, required all zero", i_rvalid, i_rdata, m_en);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({i_rvalid, d_rvalid, m_en} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_after: cycle %0d i_rvalid=%b d_rvalid=%b m_en=%b, required 000", k, i_rvalid, d_rvalid, m_en);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_withdraw();
    test_starve();
    test_reset_mid();
    checks++;
    if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d commands and %0d responses outstanding, required 0 0", cmd_q.size(), rsp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
